// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock with timeout/retry,
// and releases the downstream reset once lock has been stable long enough.
module pll_reset_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 1024,
   parameter int STABLE_CYCLES = 64,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [7:0] relock_cnt
);

   localparam int CW = $clog2(RST_CYCLES);
   localparam int TW = $clog2(LOCK_TIMEOUT);
   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   // Output bundle order: {pll_rst, sys_rst_n, ready, fail}
   function automatic logic [3:0] decode(input state_t s);
      return {(s == S_RESET), (s == S_RUN), (s == S_RUN), (s == S_FAIL)};
   endfunction

   state_t          state_r;
   logic [3:0]      outs_r;
   logic [CW-1:0]   cyc_cnt_r;
   logic [TW-1:0]   tmo_cnt_r;
   logic [SW-1:0]   stab_cnt_r;
   logic [RW-1:0]   retry_r;
   logic [7:0]      relock_r;
   logic            meta_r;
   logic            locked_s_r;

   // Two-flop synchronizer for the asynchronous PLL lock indication.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r     <= 1'b0;
         locked_s_r <= 1'b0;
      end else begin
         meta_r     <= pll_locked;
         locked_s_r <= meta_r;
      end
   end

   // Sequencer FSM; outputs are loaded with the decode of the state being entered.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_RESET;
         outs_r     <= 4'b1000;
         cyc_cnt_r  <= '0;
         tmo_cnt_r  <= '0;
         stab_cnt_r <= '0;
         retry_r    <= '0;
         relock_r   <= 8'd0;
      end else begin
         case (state_r)
            S_RESET: begin
               if (cyc_cnt_r == RST_LAST) begin
                  state_r   <= S_WAIT_LOCK;
                  outs_r    <= decode(S_WAIT_LOCK);
                  tmo_cnt_r <= '0;
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + CW'(1);
               end
            end
            S_WAIT_LOCK: begin
               // Lock takes priority over a coincident timeout.
               if (locked_s_r) begin
                  state_r    <= S_STABLE;
                  outs_r     <= decode(S_STABLE);
                  stab_cnt_r <= '0;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  if (retry_r < RETRY_MAX) begin
                     retry_r   <= retry_r + RW'(1);
                     state_r   <= S_RESET;
                     outs_r    <= decode(S_RESET);
                     cyc_cnt_r <= '0;
                  end else begin
                     state_r <= S_FAIL;
                     outs_r  <= decode(S_FAIL);
                  end
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            S_STABLE: begin
               if (!locked_s_r) begin
                  state_r   <= S_WAIT_LOCK;
                  outs_r    <= decode(S_WAIT_LOCK);
                  tmo_cnt_r <= '0;
               end else if (stab_cnt_r == STAB_LAST) begin
                  state_r <= S_RUN;
                  outs_r  <= decode(S_RUN);
               end else begin
                  stab_cnt_r <= stab_cnt_r + SW'(1);
               end
            end
            S_RUN: begin
               if (!locked_s_r) begin
                  state_r   <= S_RESET;
                  outs_r    <= decode(S_RESET);
                  cyc_cnt_r <= '0;
                  retry_r   <= '0;
                  if (relock_r != 8'd255) begin
                     relock_r <= relock_r + 8'd1;
                  end
               end
            end
            S_FAIL: begin
               state_r <= S_FAIL;
               outs_r  <= decode(S_FAIL);
            end
            default: begin
               // Illegal encoding: restart the sequence cleanly.
               state_r   <= S_RESET;
               outs_r    <= decode(S_RESET);
               cyc_cnt_r <= '0;
            end
         endcase
      end
   end

   assign pll_rst    = outs_r[3];
   assign sys_rst_n  = outs_r[2];
   assign ready      = outs_r[1];
   assign fail       = outs_r[0];
   assign relock_cnt = relock_r;

endmodule
